// File: rtl/cache_mem_arbiter_if.sv
// Cache-side bundle of cache_mem_arbiter: per-port block strobes, addresses, write data,
// the broadcast read data and the per-port stalls.
interface cache_mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int BW         = 256
);
  logic [NUM_PORTS-1:0]            p_read;
  logic [NUM_PORTS-1:0]            p_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr;
  logic [NUM_PORTS*BW-1:0]         p_wdata;
  logic [BW-1:0]                   p_rdata;
  logic [NUM_PORTS-1:0]            p_wait;

  modport master (output p_read, p_write, p_addr, p_wdata, input p_rdata, p_wait);
  modport slave  (input p_read, p_write, p_addr, p_wdata, output p_rdata, p_wait);
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between NUM_PORTS cache controllers.
// Optional CACHE_ARB_WB_LOCK_EN: a completed write-back keeps the grant for the owner's next fill.
module cache_mem_arbiter #(
  parameter int NUM_PORTS        = 2,
  parameter int ADDR_WIDTH       = 32,
  parameter int BLOCK_SIZE_BYTES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  cache_mem_arbiter_if.slave            cif,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [BLOCK_SIZE_BYTES*8-1:0] mem_wdata,
  input  logic [BLOCK_SIZE_BYTES*8-1:0] mem_rdata,
  input  logic                          mem_wait,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy,
  output logic                          proto_err
);
  localparam int BW = BLOCK_SIZE_BYTES * 8;
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic                  err_q, err_d;

  logic [NUM_PORTS-1:0]  req_s;
  logic                  found_s;
  logic [PW-1:0]         win_s;
  logic [PW-1:0]         cand_s;
  logic                  g_read_s;
  logic                  g_write_s;
  logic                  g_strobe_s;
  logic [NUM_PORTS-1:0]  p_wait_s;
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [BW-1:0]         wdata_a [NUM_PORTS];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return PW'(sum % 32'(NUM_PORTS));
  endfunction

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
    assign addr_a[i]  = cif.p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = cif.p_wdata[i*BW +: BW];
  end

  assign req_s      = cif.p_read | cif.p_write;
  assign g_read_s   = cif.p_read[grant_q];
  assign g_write_s  = cif.p_write[grant_q];
  assign g_strobe_s = g_read_s | g_write_s;

  // First requester at or after rr_q, wrapping past the last port.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand_s = wrap_inc(rr_q, 32'(k));
      if (!found_s && req_s[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic; a port driving read and write at once is flagged and served as a write.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    err_d   = err_q | (|(cif.p_read & cif.p_write));
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_BUSY;
          grant_d = win_s;
          rr_d    = wrap_inc(win_s, 32'd1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!g_strobe_s) begin
          err_d   = err_d | mem_wait;
          state_d = ST_IDLE;
        end else if (!mem_wait) begin
`ifdef CACHE_ARB_WB_LOCK_EN
          state_d = g_write_s ? ST_LOCK : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_LOCK: begin
`ifdef CACHE_ARB_WB_LOCK_EN
        state_d = g_read_s ? ST_BUSY : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory side follows the granted port only while a transaction is in flight.
  always_comb begin
    busy      = (state_q == ST_BUSY);
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    p_wait_s  = '1;
    if (busy) begin
      mem_addr          = addr_a[grant_q];
      mem_wdata         = wdata_a[grant_q];
      mem_write         = g_write_s;
      mem_read          = g_read_s & ~g_write_s;
      p_wait_s[grant_q] = mem_wait;
    end else begin
      p_wait_s = '1;
    end
  end

  assign cif.p_wait  = p_wait_s;
  assign cif.p_rdata = mem_rdata;
  assign grant_id    = grant_q;
  assign proto_err   = err_q;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end
endmodule
